// File: rtl/br_flow_join_collect_pkg.sv
// Shared types for the collecting flow join: FSM state encoding.
package br_flow_join_collect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/br_counter_incr.sv
// Free-running increment-by-one counter that wraps modulo 2^Width.
module br_counter_incr #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_q;
  logic [Width-1:0] value_d;

  assign value_d = incr ? value_q + 1'b1 : value_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/br_flow_join_collect.sv
// N-way flow join sequencer: collects independent per-flow handshakes for the
// flows in a per-transaction mask, then presents one pop with that mask.
module br_flow_join_collect
  import br_flow_join_collect_pkg::*;
#(
  parameter int NumFlows                       = 2,
  parameter int CountWidth                     = 16,
  parameter bit EnableAssertPushValidStability = 1'b1,
  parameter bit EnableAssertFinalNotValid      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumFlows-1:0]   cfg_mask,
  input  logic [NumFlows-1:0]   push_valid,
  output logic [NumFlows-1:0]   push_ready,
  input  logic                  pop_ready,
  output logic                  pop_valid,
  output logic [NumFlows-1:0]   pop_mask,
  output logic [CountWidth-1:0] join_count,
  output logic                  busy
);

  if (NumFlows < 2) begin : gen_bad_num_flows
    $error("NumFlows must be >= 2");
  end
  if (CountWidth < 1) begin : gen_bad_count_width
    $error("CountWidth must be >= 1");
  end

  state_e              state_q, state_d;
  logic [NumFlows-1:0] arrived_q, arrived_d;
  logic [NumFlows-1:0] pop_mask_q, pop_mask_d;
  logic [NumFlows-1:0] eff_mask;
  logic [NumFlows-1:0] hs;
  logic                done;
  logic                pop_fire;

  // The mask is only open to change while idle; afterwards the captured copy rules.
  assign eff_mask   = (state_q == IDLE) ? cfg_mask : pop_mask_q;
  assign push_ready = (rst || state_q == EMIT) ? '0 : (eff_mask & ~arrived_q);
  assign hs         = push_valid & push_ready;
  assign done       = ((arrived_q | hs) == eff_mask) && (eff_mask != '0);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    arrived_d  = arrived_q;
    pop_mask_d = pop_mask_q;
    pop_fire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs != '0) begin
          pop_mask_d = cfg_mask;
          arrived_d  = hs;
          state_d    = done ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        arrived_d = arrived_q | hs;
        if (done) state_d = EMIT;
      end
      EMIT: begin
        if (pop_ready) begin
          pop_fire  = 1'b1;
          arrived_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      arrived_q  <= '0;
      pop_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      arrived_q  <= arrived_d;
      pop_mask_q <= pop_mask_d;
    end
  end

  br_counter_incr #(
    .Width (CountWidth)
  ) u_join_counter (
    .clk   (clk),
    .rst   (rst),
    .incr  (pop_fire),
    .value (join_count)
  );

  assign pop_valid = !rst && (state_q == EMIT);
  assign busy      = !rst && (state_q != IDLE);
  assign pop_mask  = pop_mask_q;

  if (EnableAssertPushValidStability) begin : gen_push_stability
    for (genvar i = 0; i < NumFlows; i++) begin : gen_flow
      a_push_valid_stable: assert property (@(posedge clk) disable iff (rst)
        (push_valid[i] && !push_ready[i] && eff_mask[i] && !arrived_q[i]) |=> push_valid[i]);
    end
  end

  a_pop_valid_held: assert property (@(posedge clk) disable iff (rst)
    (pop_valid && !pop_ready) |=> pop_valid);
  a_pop_mask_nonzero: assert property (@(posedge clk) disable iff (rst)
    pop_valid |-> (pop_mask != '0));

  if (EnableAssertFinalNotValid) begin : gen_final_idle
    final begin
      a_final_not_valid: assert ((push_valid == '0) && !pop_valid);
    end
  end

endmodule

// File: tb/tb_br_flow_join_collect.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// against a set-based reference model of the join.
module tb_br_flow_join_collect;

  localparam int NF = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] cfg_mask;
  logic [NF-1:0] push_valid;
  logic [NF-1:0] push_ready;
  logic          pop_ready;
  logic          pop_valid;
  logic [NF-1:0] pop_mask;
  logic [CW-1:0] join_count;
  logic          busy;

  br_flow_join_collect #(
    .NumFlows   (NF),
    .CountWidth (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mask   (cfg_mask),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .pop_mask   (pop_mask),
    .join_count (join_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: a transaction is "open" once its first flow hands off,
  // "full" once every flow of its mask has been collected.
  bit            m_open;
  bit            m_full;
  logic [NF-1:0] m_mask;
  logic [NF-1:0] m_got;
  int            m_joins;
  logic [NF-1:0] last_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NF-1:0] exp_ready();
    if (rst || m_full) return '0;
    return (m_open ? m_mask : cfg_mask) & ~m_got;
  endfunction

  // One clock: check outputs mid-cycle, advance the model, step past the edge.
  task automatic tick();
    logic [NF-1:0] rdy;
    @(negedge clk);
    rdy = exp_ready();
    chk("push_ready", 32'(push_ready), 32'(rdy));
    chk("pop_valid",  32'(pop_valid),  32'(!rst && m_full));
    chk("busy",       32'(busy),       32'(!rst && m_open));
    chk("pop_mask",   32'(pop_mask),   32'(m_mask));
    chk("join_count", 32'(join_count), 32'(m_joins % (1 << CW)));
    last_hs = push_valid & rdy;
    if (rst) begin
      m_open = 0; m_full = 0; m_mask = '0; m_got = '0; m_joins = 0;
    end else if (m_full) begin
      if (pop_ready) begin
        m_joins++;
        m_open = 0; m_full = 0; m_got = '0;
      end
    end else if (last_hs != '0) begin
      if (!m_open) begin
        m_open = 1; m_mask = cfg_mask; m_got = last_hs;
      end else begin
        m_got = m_got | last_hs;
      end
      if (m_got == m_mask) m_full = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_open = 0; m_full = 0; m_mask = '0; m_got = '0; m_joins = 0; last_hs = '0;
    rst = 1'b1; cfg_mask = '0; push_valid = '0; pop_ready = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;

    // All flows in one cycle: IDLE -> EMIT, pop next cycle.
    cfg_mask = 3'b111; pop_ready = 1'b1;
    push_valid = 3'b111; tick();
    push_valid = 3'b000; tick(); tick();

    // Staggered arrivals 0, 2, 1.
    push_valid = 3'b001; tick();
    push_valid = 3'b000; tick();
    push_valid = 3'b100; tick();
    push_valid = 3'b000; tick();
    push_valid = 3'b010; tick();
    push_valid = 3'b000; tick(); tick();

    // Non-masked flow 1 held valid throughout.
    cfg_mask = 3'b101;
    push_valid = 3'b010; tick(); tick();
    push_valid = 3'b011; tick();
    push_valid = 3'b110; tick();
    push_valid = 3'b010; tick();
    push_valid = 3'b000; tick();

    // Backpressure in EMIT.
    cfg_mask = 3'b111; pop_ready = 1'b0;
    push_valid = 3'b111; tick();
    push_valid = 3'b000;
    repeat (4) tick();
    pop_ready = 1'b1; tick(); tick();

    // Reset in the middle of a collection.
    push_valid = 3'b011; tick();
    push_valid = 3'b000; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    push_valid = 3'b111; tick();
    push_valid = 3'b000; tick(); tick();

    // Empty mask: nothing is ready, nothing changes.
    cfg_mask = 3'b000; push_valid = 3'b111;
    repeat (3) tick();
    push_valid = 3'b000;

    // Back-to-back joins across the counter wrap.
    cfg_mask = 3'b111; pop_ready = 1'b1;
    repeat (5) begin
      push_valid = 3'b111; tick();
      push_valid = 3'b000; tick();
    end

    // Randomized traffic; a raised valid is held until it hands off.
    last_hs = '0;
    repeat (400) begin
      if (!m_open) cfg_mask = NF'($urandom_range(0, 7));
      pop_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NF; i++)
        if (last_hs[i] || !push_valid[i]) push_valid[i] = ($urandom_range(0, 2) == 0);
      tick();
    end

    rst = 1'b0; push_valid = '0; pop_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
